// File: rtl/fb_rect_fill.sv
// rtl/fb_rect_fill.sv - clipped rectangle fill into a 640x480 RGB333 framebuffer
// Optional vblank-only write gating: define FB_FILL_VBLANK_ONLY_EN.
module fb_rect_fill (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [9:0]  cmd_x0,
  input  logic [8:0]  cmd_y0,
  input  logic [9:0]  cmd_w,
  input  logic [8:0]  cmd_h,
  input  logic [8:0]  cmd_colour,
  output logic        wr_en,
  input  logic        wr_grant,
  output logic [18:0] wr_addr,
  output logic [8:0]  wr_data,
  input  logic        vblank,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {S_IDLE, S_CLIP, S_WRITE, S_DONE} state_t;

  state_t      r_state;
  logic [9:0]  r_x0;
  logic [8:0]  r_y0;
  logic [9:0]  r_w;
  logic [8:0]  r_h;
  logic [8:0]  r_colour;
  logic [9:0]  r_x_end;
  logic [8:0]  r_y_end;
  logic [9:0]  r_x;
  logic [8:0]  r_y;
  logic [18:0] r_row_base;
  logic [18:0] r_addr;
  logic        r_wr_en;
  logic        r_done;

  logic [10:0] w_x_sum;
  logic [9:0]  w_y_sum;
  logic [9:0]  w_x_lim;
  logic [9:0]  w_y_lim;
  logic [9:0]  w_x_end;
  logic [8:0]  w_y_end;
  logic        w_empty;
  logic [18:0] w_y0_base;
  logic [18:0] w_next_base;
  logic        w_gate;
  logic        w_fire;

  // Sums are one bit wider than the operands so a large w/h cannot wrap.
  assign w_x_sum     = {1'b0, r_x0} + {1'b0, r_w};
  assign w_y_sum     = {1'b0, r_y0} + {1'b0, r_h};
  assign w_x_lim     = (w_x_sum > 11'd640) ? 10'd640 : w_x_sum[9:0];
  assign w_y_lim     = (w_y_sum > 10'd480) ? 10'd480 : w_y_sum;
  assign w_x_end     = w_x_lim - 10'd1;
  assign w_y_end     = w_y_lim[8:0] - 9'd1;
  assign w_empty     = (r_w == 10'd0) || (r_h == 9'd0) || (r_x0 >= 10'd640) || (r_y0 >= 9'd480);
  assign w_y0_base   = {1'b0, r_y0, 9'b0} + {3'b0, r_y0, 7'b0};
  assign w_next_base = r_row_base + 19'd640;

`ifdef FB_FILL_VBLANK_ONLY_EN
  assign w_gate = vblank;
`else
  logic w_unused_vblank;
  assign w_unused_vblank = vblank;
  assign w_gate = 1'b1;
`endif

  assign wr_en     = r_wr_en & w_gate;
  assign w_fire    = wr_en & wr_grant;
  assign wr_addr   = r_addr;
  assign wr_data   = r_colour;
  assign cmd_ready = (r_state == S_IDLE);
  assign busy      = (r_state != S_IDLE);
  assign done      = r_done;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_x0       <= '0;
      r_y0       <= '0;
      r_w        <= '0;
      r_h        <= '0;
      r_colour   <= '0;
      r_x_end    <= '0;
      r_y_end    <= '0;
      r_x        <= '0;
      r_y        <= '0;
      r_row_base <= '0;
      r_addr     <= '0;
      r_wr_en    <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (cmd_valid) begin
            r_x0     <= cmd_x0;
            r_y0     <= cmd_y0;
            r_w      <= cmd_w;
            r_h      <= cmd_h;
            r_colour <= cmd_colour;
            r_state  <= S_CLIP;
          end
        end
        S_CLIP: begin
          if (w_empty) begin
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            // Address is only loaded for an in-range origin, so it never leaves the frame.
            r_x_end    <= w_x_end;
            r_y_end    <= w_y_end;
            r_x        <= r_x0;
            r_y        <= r_y0;
            r_row_base <= w_y0_base;
            r_addr     <= w_y0_base + {9'b0, r_x0};
            r_wr_en    <= 1'b1;
            r_state    <= S_WRITE;
          end
        end
        S_WRITE: begin
          if (w_fire) begin
            if (r_x == r_x_end) begin
              if (r_y == r_y_end) begin
                r_wr_en <= 1'b0;
                r_done  <= 1'b1;
                r_state <= S_DONE;
              end else begin
                r_x        <= r_x0;
                r_y        <= r_y + 9'd1;
                r_row_base <= w_next_base;
                r_addr     <= w_next_base + {9'b0, r_x0};
              end
            end else begin
              r_x    <= r_x + 10'd1;
              r_addr <= r_addr + 19'd1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fb_rect_fill.sv
// tb/tb_fb_rect_fill.sv - directed self-checking bench for fb_rect_fill
module tb_fb_rect_fill;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [9:0]  cmd_x0 = '0;
  logic [8:0]  cmd_y0 = '0;
  logic [9:0]  cmd_w = '0;
  logic [8:0]  cmd_h = '0;
  logic [8:0]  cmd_colour = '0;
  logic        wr_en;
  logic        wr_grant = 1'b1;
  logic [18:0] wr_addr;
  logic [8:0]  wr_data;
  logic        vblank = 1'b0;
  logic        busy;
  logic        done;

  int n_checks = 0;
  int n_errors = 0;

  int wr_q[$];
  int stall_q[$];
  int first_wr, done_cyc, ready_cyc, last_grant, n_done, bad_data, over_max;
  int stall_idx = -1;
  int stall_left = 0;
  logic scramble = 1'b0;
  logic [8:0] exp_col;

  fb_rect_fill u_dut (
    .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_x0(cmd_x0), .cmd_y0(cmd_y0), .cmd_w(cmd_w), .cmd_h(cmd_h),
    .cmd_colour(cmd_colour), .wr_en(wr_en), .wr_grant(wr_grant),
    .wr_addr(wr_addr), .wr_data(wr_data), .vblank(vblank), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic chk_q(input string tag, input int got[$], input int exp[$]);
    chk({tag, "_len"}, 32'(got.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size() && i < got.size(); i++)
      chk($sformatf("%s_%0d", tag, i), 32'(got[i]), 32'(exp[i]));
  endtask

  // Caller is at a negedge with the DUT idle; accept happens on the next posedge.
  task automatic send_cmd(input logic [9:0] x0, input logic [8:0] y0,
                          input logic [9:0] w, input logic [8:0] h, input logic [8:0] col);
    cmd_x0 = x0; cmd_y0 = y0; cmd_w = w; cmd_h = h; cmd_colour = col;
    exp_col = col;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  // Cycle c counts negedges after the accept edge (c=0 is the CLIP cycle).
  task automatic collect(input int budget);
    wr_q.delete(); stall_q.delete();
    first_wr = -1; done_cyc = -1; ready_cyc = -1; last_grant = -1;
    n_done = 0; bad_data = 0; over_max = 0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (scramble) begin
        cmd_x0 = 10'($urandom); cmd_y0 = 9'($urandom);
        cmd_w = 10'($urandom); cmd_h = 9'($urandom); cmd_colour = 9'($urandom);
      end
      if (wr_en && stall_left > 0 && wr_q.size() == stall_idx) begin
        wr_grant = 1'b0;
        stall_left--;
        stall_q.push_back(int'(wr_addr));
      end else begin
        wr_grant = 1'b1;
      end
      if (wr_en && first_wr < 0) first_wr = c;
      if (wr_en && wr_addr > 19'd307199) over_max++;
      if (wr_en && wr_grant) begin
        wr_q.push_back(int'(wr_addr));
        last_grant = c;
        if (wr_data !== exp_col) bad_data++;
      end
      if (done) begin
        done_cyc = c;
        n_done++;
      end
      if (cmd_ready) begin
        ready_cyc = c;
        break;
      end
    end
    chk("timeout", 32'(ready_cyc >= 0), 32'd1);
    chk("data", 32'(bad_data), 32'd0);
    chk("addr_max", 32'(over_max), 32'd0);
    chk("n_done", 32'(n_done), 32'd1);
  endtask

  initial begin
`ifdef FB_FILL_VBLANK_ONLY_EN
    vblank = 1'b1;
`else
    vblank = 1'b0;
`endif
    #23;
    chk("rst_state", {cmd_ready, wr_en, busy, done}, 4'b1000);
    chk("rst_addr", 32'(wr_addr), 32'd0);
    chk("rst_data", 32'(wr_data), 32'd0);

    // First command on the first edge after release, 2x2 at origin.
    @(negedge clk);
    reset_n = 1'b1;
    send_cmd(10'd0, 9'd0, 10'd2, 9'd2, 9'h1FF);
    collect(40);
    chk_q("t2x2", wr_q, '{0, 1, 640, 641});
    chk("t2x2_first", 32'(first_wr), 32'd1);
    chk("t2x2_done", 32'(done_cyc), 32'(last_grant + 1));
    chk("t2x2_ready", 32'(ready_cyc), 32'd6);

    // Clipped at the bottom-right corner.
    send_cmd(10'd638, 9'd479, 10'd5, 9'd5, 9'h0A5);
    collect(40);
    chk_q("corner", wr_q, '{307198, 307199});

    // Empty commands: zero width, x0 out of range, both origins maxed.
    send_cmd(10'd5, 9'd5, 10'd0, 9'd3, 9'h011);
    collect(20);
    chk("w0_nwr", 32'(wr_q.size()), 32'd0);
    chk("w0_first", 32'(first_wr), 32'hFFFFFFFF);
    chk("w0_done", 32'(done_cyc), 32'd1);
    chk("w0_ready", 32'(ready_cyc), 32'd2);
    send_cmd(10'd700, 9'd5, 10'd4, 9'd3, 9'h022);
    collect(20);
    chk("x700_nwr", 32'(wr_q.size()), 32'd0);
    chk("x700_done", 32'(done_cyc), 32'd1);
    send_cmd(10'd1023, 9'd511, 10'd1023, 9'd511, 9'h033);
    collect(20);
    chk("maxorg_nwr", 32'(wr_q.size()), 32'd0);

    // Grant withheld three cycles on the second pixel.
    stall_idx = 1; stall_left = 3;
    send_cmd(10'd10, 9'd1, 10'd3, 9'd1, 9'h155);
    collect(40);
    chk_q("stall_seq", wr_q, '{650, 651, 652});
    chk_q("stall_hold", stall_q, '{651, 651, 651});
    stall_idx = -1;

    // Right-edge clip over two rows while cmd_* churns underneath.
    scramble = 1'b1;
    send_cmd(10'd637, 9'd10, 10'd10, 9'd2, 9'h0F0);
    collect(40);
    scramble = 1'b0;
    chk_q("redge", wr_q, '{7037, 7038, 7039, 7677, 7678, 7679});

    // Reset during the fourth write of a 4x4 fill.
    send_cmd(10'd0, 9'd0, 10'd4, 9'd4, 9'h077);
    exp_col = 9'h077;
    repeat (5) @(negedge clk);
    chk("rst4_wr_en", 32'(wr_en), 32'd1);
    chk("rst4_addr", 32'(wr_addr), 32'd3);
    reset_n = 1'b0;
    #1;
    chk("rst4_async", {wr_en, busy, cmd_ready}, 3'b001);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst4_quiet", {done, wr_en}, 2'b00);
    end
    reset_n = 1'b1;
    send_cmd(10'd3, 9'd0, 10'd1, 9'd1, 9'h1C0);
    collect(20);
    chk_q("after_rst", wr_q, '{3});
    chk("after_rst_first", 32'(first_wr), 32'd1);

`ifdef FB_FILL_VBLANK_ONLY_EN
    // Writes held off until vblank rises.
    begin
      int seen;
      seen = 0;
      vblank = 1'b0;
      send_cmd(10'd0, 9'd5, 10'd4, 9'd1, 9'h0AA);
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        if (wr_en) seen++;
      end
      chk("vb_gated", 32'(seen), 32'd0);
      vblank = 1'b1;
      collect(40);
      chk_q("vb_writes", wr_q, '{3200, 3201, 3202, 3203});
    end
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fb_rect_fill.md
FB_RECT_FILL -- requirements
Module: fb_rect_fill

Interface
REQ-001 SHALL have port: clk  input  1  pixel/system clock; all state changes on rising edge.
REQ-002 SHALL have port: reset_n  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port: cmd_valid  input  1  fill command present.
REQ-004 SHALL have port: cmd_ready  output  1  block can accept a command.
REQ-005 SHALL have port: cmd_x0  input  10  left column, 0..639.
REQ-006 SHALL have port: cmd_y0  input  9  top row, 0..479.
REQ-007 SHALL have port: cmd_w  input  10  width in pixels.
REQ-008 SHALL have port: cmd_h  input  9  height in pixels.
REQ-009 SHALL have port: cmd_colour  input  9  RGB333 fill value, R[8:6] G[5:3] B[2:0].
REQ-010 SHALL have port: wr_en  output  1  framebuffer write request.
REQ-011 SHALL have port: wr_grant  input  1  memory accepts the write this cycle.
REQ-012 SHALL have port: wr_addr  output  19  framebuffer word address, y*640+x.
REQ-013 SHALL have port: wr_data  output  9  RGB333 write value.
REQ-014 SHALL have port: vblank  input  1  vertical blanking from display timing; used only under REQ-034.
REQ-015 SHALL have port: busy  output  1  command in progress.
REQ-016 SHALL have port: done  output  1  one-cycle pulse when a command finishes.

Function
REQ-017 SHALL implement states IDLE, CLIP, WRITE, DONE.
REQ-018 SHALL assert cmd_ready only in IDLE; command is accepted when cmd_valid && cmd_ready on a rising edge, and all cmd_* fields are captured at that edge.
REQ-019 SHALL go IDLE -> CLIP on accept; busy SHALL be high in CLIP, WRITE and DONE.
REQ-020 In CLIP the block SHALL clip: x_end = min(x0+w, 640) - 1; y_end = min(y0+h, 480) - 1; sums SHALL be computed 11/10 bits wide with no wrap.
REQ-021 SHALL go CLIP -> DONE with zero writes when w==0, h==0, x0>=640 or y0>=480.
REQ-022 Otherwise CLIP -> WRITE, with the first wr_en asserted two cycles after the accept edge.
REQ-023 Addressing SHALL be incremental: row base starts at y0*640 (shift-add: y0<<9 + y0<<7), +640 per row, + x offset; there SHALL be no general multiplier.
REQ-024 Writes SHALL be raster order: x from x0 to x_end, then the next row, ending at (x_end, y_end).
REQ-025 wr_en, wr_addr and wr_data SHALL hold stable until wr_grant is high; the block SHALL advance one pixel per cycle where wr_en && wr_grant.
REQ-026 After the grant of the last pixel the block SHALL enter DONE, drop wr_en on the next cycle, pulse done high for exactly one cycle, then return to IDLE.
REQ-027 wr_data SHALL equal the captured cmd_colour for the whole command.
REQ-028 wr_addr SHALL never exceed 307199 for any input values.
REQ-029 cmd_* changes while busy SHALL have no effect.

Reset
REQ-030 While reset_n is low the block SHALL be in IDLE with cmd_ready=1, wr_en=0, busy=0, done=0, wr_addr=0 and wr_data=0, without waiting for clk.
REQ-031 Reset asserted mid-command SHALL abandon the command immediately, with no further writes and no done pulse.
REQ-032 The first command SHALL be accepted on the first rising edge after reset_n deasserts.

Configuration
REQ-033 Macro FB_FILL_VBLANK_ONLY_EN SHALL select write gating.
REQ-034 With FB_FILL_VBLANK_ONLY_EN defined, wr_en SHALL be high only while vblank is high. If vblank falls with a write pending, wr_en SHALL drop, the pending pixel SHALL not advance, and the write SHALL resume with the same addr/data when vblank rises.
REQ-035 Without FB_FILL_VBLANK_ONLY_EN, vblank SHALL be ignored and writes SHALL proceed whenever in WRITE.

Verification
REQ-036 Fill x0=0,y0=0,w=2,h=2,colour=9'h1FF, wr_grant tied 1 -> addresses 0,1,640,641; first wr_en 2 cycles after accept; done 1 cycle after last grant.
REQ-037 Fill x0=638,y0=479,w=5,h=5 -> exactly 2 writes, at 307198 and 307199, then done.
REQ-038 Fill w=0 (or x0=700) -> no wr_en; done pulses 2 cycles after accept; cmd_ready returns the next cycle.
REQ-039 Fill x0=10,y0=1,w=3,h=1 with wr_grant low for 3 cycles on the 2nd pixel -> wr_addr held at 651 for all 3 cycles; sequence 650,651,652.
REQ-040 Reset_n pulled low during the 4th write of a 4x4 fill -> wr_en=0 and busy=0 asynchronously; no done pulse; a new command is accepted after release.
REQ-041 With FB_FILL_VBLANK_ONLY_EN, a 1x4 fill with vblank low then high after 10 cycles -> no wr_en during those 10 cycles; 4 writes once vblank is high.
